abc: RTL and testbench
======================

ABC -- requirements
Module: abc

Interface
REQ-001 SHALL be one clock domain; reset is synchronous and active-low.
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset_  input  1  synchronous active-low reset, sampled on rising edge of clock.
REQ-004 soc1  output  1  start-of-conversion to A/D converter 1, registered.
REQ-005 eoc1  input  1  end-of-conversion from converter 1; 1 = idle/data valid, 0 = converting.
REQ-006 x1  input  8  unsigned sample from converter 1, valid while eoc1=1 after a conversion.
REQ-007 soc2  output  1  start-of-conversion to A/D converter 2, registered.
REQ-008 eoc2  input  1  end-of-conversion from converter 2, same meaning as eoc1.
REQ-009 x2  input  8  unsigned sample from converter 2.
REQ-010 out  output  1  registered pulse; high time in clock periods = (x1+x2)/2.

Function
REQ-011 SHALL run an endless loop: convert both channels, compute N, emit pulse of N periods, repeat.
REQ-012 SHALL use FSM states IDLE, SOC, EOC_WAIT, PULSE.
REQ-013 IDLE: soc1=soc2=0, out=0; when eoc1=1 and eoc2=1, set soc1=soc2=1, go SOC.
REQ-014 SOC: hold soc1=soc2=1 until eoc1=0 and eoc2=0 in the same cycle; then soc1=soc2=0, go EOC_WAIT.
REQ-015 Converters may drop eoc at different cycles; soc stays 1 until both are 0.
REQ-016 EOC_WAIT: wait until eoc1=1 and eoc2=1 in the same cycle; in that cycle sample x1, x2.
REQ-017 N SHALL be computed as 9-bit sum x1+x2, right shifted by 1 (truncating), 8-bit result, range 0..255.
REQ-018 If N=0: out stays 0, go IDLE (no pulse, next conversion starts).
REQ-019 If N>0: set out=1, load 8-bit counter with N, go PULSE.
REQ-020 PULSE: counter decrements each cycle; on the edge where counter=1, out=0 and go IDLE.
REQ-021 Out SHALL be high for exactly N rising edges: set at edge k, cleared at edge k+N.
REQ-022 x1/x2 SHALL NOT be sampled while eoc is 0 or before both eoc return to 1; X on x inputs outside that cycle has no effect.
REQ-023 Out SHALL be glitch-free (flip-flop driven); soc1 and soc2 always equal.

Reset
REQ-024 While reset_=0 at a rising edge: state=IDLE, soc1=0, soc2=0, out=0, counter=0.
REQ-025 Reset mid-conversion or mid-pulse SHALL abort immediately: out and soc fall at that edge, no partial pulse resumes.
REQ-026 Outputs SHALL be 0 from the first edge after reset until the FSM leaves IDLE.

Structure
REQ-027 Shared package SHALL hold state encoding (2-bit, IDLE=0, SOC=1, EOC_WAIT=2, PULSE=3) and data width constant 8.
REQ-028 Single module; no sub-module needed (optional sub-module avg8 computing N combinationally).

Verification
REQ-029 x1=10, x2=20, converter 1 drops eoc 1 cycle after soc, converter 2 after 2 cycles -> out high exactly 15 periods.
REQ-030 x1=22, x2=11 -> out high 16 periods (truncation of 16.5).
REQ-031 x1=0, x2=0 -> no out pulse; soc1/soc2 rise again for the next conversion.
REQ-032 x1=255, x2=255 -> out high 255 periods (9-bit sum, no overflow).
REQ-033 16 back-to-back conversions with x1=i+10, x2=2(i+10) (swapped on odd i) -> every pulse width matches (x1+x2)/2.
REQ-034 reset_ asserted for one edge during a pulse -> out=0, soc1=soc2=0 at that edge; a new conversion then starts normally.

Source files
------------

// File: rtl/abc_pkg.sv
// -----------------------------------------------------------------------------
// abc_pkg -- shared definitions for the dual A/D converter pulse generator.
//   DATA_W      : converter sample width (8 bits)
//   abc_state_t : 2-bit FSM encoding (IDLE=0, SOC=1, EOC_WAIT=2, PULSE=3)
// -----------------------------------------------------------------------------
package abc_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SOC      = 2'd1,
      EOC_WAIT = 2'd2,
      PULSE    = 2'd3
   } abc_state_t;

endpackage : abc_pkg

// File: rtl/abc_avg8.sv
// -----------------------------------------------------------------------------
// abc_avg8 -- combinational truncating average of two unsigned samples.
//   a, b : DATA_W-bit unsigned inputs
//   n    : (a + b) >> 1, formed from a DATA_W+1 bit sum so no carry is lost
// -----------------------------------------------------------------------------
module abc_avg8
   import abc_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] n
);

   // The sum keeps its carry bit; dropping the LSB truncates toward zero and
   // the result always fits back into DATA_W bits (max 255).
   function automatic logic [DATA_W-1:0] avg_trunc(input logic [DATA_W-1:0] p,
                                                   input logic [DATA_W-1:0] q);
      logic [DATA_W:0] sum;
      sum = {1'b0, p} + {1'b0, q};
      return sum[DATA_W:1];
   endfunction

   assign n = avg_trunc(a, b);

endmodule : abc_avg8

// File: rtl/abc.sv
// -----------------------------------------------------------------------------
// abc -- drives two A/D converters in lock-step, averages their samples and
//        emits one output pulse whose width in clock periods is the average.
//   clock      : system clock, all state on the rising edge
//   reset_     : synchronous active-low reset
//   soc1/soc2  : registered start-of-conversion to converters 1/2 (always equal)
//   eoc1/eoc2  : end-of-conversion, 1 = idle/data valid, 0 = converting
//   x1/x2      : unsigned samples, only looked at in the cycle both eoc are 1
//                after a conversion
//   out        : registered pulse, high for (x1+x2)/2 clock periods
// -----------------------------------------------------------------------------
module abc
   import abc_pkg::*;
(
   input  logic              clock,
   input  logic              reset_,
   output logic              soc1,
   input  logic              eoc1,
   input  logic [DATA_W-1:0] x1,
   output logic              soc2,
   input  logic              eoc2,
   input  logic [DATA_W-1:0] x2,
   output logic              out
);

   abc_state_t        state;
   abc_state_t        state_nxt;
   logic              soc_q;
   logic              soc_nxt;
   logic              out_q;
   logic              out_nxt;
   logic [DATA_W-1:0] cnt_q;
   logic [DATA_W-1:0] cnt_nxt;
   logic [DATA_W-1:0] n;
   logic              both_idle;
   logic              both_busy;

   assign both_idle = eoc1 & eoc2;
   assign both_busy = ~eoc1 & ~eoc2;

   abc_avg8 u_avg8 (
      .a (x1),
      .b (x2),
      .n (n)
   );

   // ---- state register: FSM state, registered outputs and pulse counter ----
   always_ff @(posedge clock) begin
      if (!reset_) begin
         state <= IDLE;
         soc_q <= 1'b0;
         out_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         state <= state_nxt;
         soc_q <= soc_nxt;
         out_q <= out_nxt;
         cnt_q <= cnt_nxt;
      end
   end

   // ---- next-state logic ----
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (both_idle) state_nxt = SOC;
         SOC:      if (both_busy) state_nxt = EOC_WAIT;
         EOC_WAIT: if (both_idle) state_nxt = (n == '0) ? IDLE : PULSE;
         PULSE:    if (cnt_q == DATA_W'(1)) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // ---- output logic: next values of the registered outputs and counter ----
   // Outputs are computed one cycle ahead so every port is a flop output.
   // The samples only steer anything in the EOC_WAIT cycle where both
   // converters report idle; in every other state n is ignored.
   always_comb begin
      soc_nxt = 1'b0;
      out_nxt = 1'b0;
      cnt_nxt = cnt_q;
      case (state)
         IDLE: begin
            soc_nxt = both_idle;
         end
         SOC: begin
            // Converters may drop eoc on different cycles; keep requesting
            // until both have acknowledged in the same cycle.
            soc_nxt = ~both_busy;
         end
         EOC_WAIT: begin
            if (both_idle) begin
               out_nxt = (n != '0);
               cnt_nxt = n;
            end
         end
         PULSE: begin
            // Counter holds the remaining high periods including this one;
            // out falls on the edge where it reaches 1.
            out_nxt = (cnt_q != DATA_W'(1));
            cnt_nxt = cnt_q - DATA_W'(1);
         end
         default: begin
            soc_nxt = 1'b0;
         end
      endcase
   end

   assign soc1 = soc_q;
   assign soc2 = soc_q;
   assign out  = out_q;

endmodule : abc

// File: tb/tb_abc.sv
// -----------------------------------------------------------------------------
// tb_abc -- self-checking bench for abc. Two behavioural converters are driven
// from tasks; the expected pulse width is the plain integer average of the two
// samples handed to the converters.
// -----------------------------------------------------------------------------
module tb_abc;

   logic       clock;
   logic       reset_;
   logic       soc1;
   logic       eoc1;
   logic [7:0] x1;
   logic       soc2;
   logic       eoc2;
   logic [7:0] x2;
   logic       out;

   int checks   = 0;
   int failures = 0;

   abc dut (
      .clock  (clock),
      .reset_ (reset_),
      .soc1   (soc1),
      .eoc1   (eoc1),
      .x1     (x1),
      .soc2   (soc2),
      .eoc2   (eoc2),
      .x2     (x2),
      .out    (out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Converter handshake: wait for soc, drop eoc1/eoc2 after d1/d2 cycles,
   // convert a few cycles, then raise eoc1 with x1=a and eoc2 (possibly later)
   // with x2=b. Returns aligned to a negedge with both eoc high.
   task automatic start_conv(input logic [7:0] a, input logic [7:0] b,
                             input int d1, input int d2, output bit ok);
      int t;
      int j;
      int c;
      int skew;
      ok = 1'b0;
      t  = 0;
      while (soc1 !== 1'b1 && t < 40) begin
         @(negedge clock);
         t++;
      end
      checks++;
      if (soc1 !== 1'b1) begin
         $display("FAIL soc_start: soc1=%b after %0d cycles, required 1", soc1, t);
         failures++;
         return;
      end
      checks++;
      if (soc2 !== 1'b1) begin
         $display("FAIL soc_equal: soc2=%b, required 1 with soc1", soc2);
         failures++;
      end
      j = 0;
      while (eoc1 || eoc2) begin
         @(negedge clock);
         j++;
         checks++;
         if (soc1 !== 1'b1 || soc2 !== 1'b1) begin
            $display("FAIL soc_hold: soc1=%b soc2=%b, required 1 1", soc1, soc2);
            failures++;
         end
         if (j >= d1) eoc1 = 1'b0;
         if (j >= d2) eoc2 = 1'b0;
         x1 = 8'($urandom);
         x2 = 8'($urandom);
      end
      @(negedge clock);
      checks++;
      if (soc1 !== 1'b0 || soc2 !== 1'b0) begin
         $display("FAIL soc_drop: soc1=%b soc2=%b, required 0 0", soc1, soc2);
         failures++;
      end
      c = $urandom_range(1, 3);
      repeat (c) begin
         @(negedge clock);
         x1 = 8'($urandom);
         x2 = 8'($urandom);
         checks++;
         if (soc1 !== 1'b0 || out !== 1'b0) begin
            $display("FAIL busy_idle: soc1=%b out=%b, required 0 0", soc1, out);
            failures++;
         end
      end
      eoc1 = 1'b1;
      x1   = a;
      skew = $urandom_range(0, 2);
      repeat (skew) begin
         @(negedge clock);
         checks++;
         if (out !== 1'b0 || soc1 !== 1'b0) begin
            $display("FAIL early_out: out=%b soc1=%b with eoc2=0, required 0 0", out, soc1);
            failures++;
         end
      end
      eoc2 = 1'b1;
      x2   = b;
      ok   = 1'b1;
   endtask

   // Counts negedges with out high after the sampling edge; samples are
   // scrambled right after sampling to show they no longer matter.
   task automatic measure_pulse(output int width);
      width = 0;
      @(negedge clock);
      x1 = 8'($urandom);
      x2 = 8'($urandom);
      while (out === 1'b1 && width < 300) begin
         width++;
         if (soc1 !== 1'b0) begin
            checks++;
            $display("FAIL soc_in_pulse: soc1=%b, required 0", soc1);
            failures++;
         end
         @(negedge clock);
      end
   endtask

   task automatic run_one(input string name, input logic [7:0] a, input logic [7:0] b,
                          input int d1, input int d2);
      bit ok;
      int w;
      int expw;
      expw = (int'(a) + int'(b)) / 2;
      start_conv(a, b, d1, d2, ok);
      if (ok) begin
         measure_pulse(w);
         checks++;
         if (w !== expw) begin
            $display("FAIL %s: x1=%0d x2=%0d pulse width=%0d, required %0d", name, a, b, w, expw);
            failures++;
         end
      end
   endtask

   task automatic test_reset();
      reset_ = 1'b0;
      eoc1   = 1'b0;
      eoc2   = 1'b0;
      x1     = 8'hxx;
      x2     = 8'hxx;
      repeat (3) @(negedge clock);
      checks++;
      if (soc1 !== 1'b0 || soc2 !== 1'b0 || out !== 1'b0) begin
         $display("FAIL reset_state: soc1=%b soc2=%b out=%b, required 0 0 0", soc1, soc2, out);
         failures++;
      end
      reset_ = 1'b1;
      repeat (4) begin
         @(negedge clock);
         checks++;
         if (soc1 !== 1'b0 || soc2 !== 1'b0 || out !== 1'b0) begin
            $display("FAIL post_reset_idle: soc1=%b soc2=%b out=%b, required 0 0 0", soc1, soc2, out);
            failures++;
         end
      end
      eoc1 = 1'b1;
      eoc2 = 1'b1;
   endtask

   task automatic test_basic();
      run_one("basic_10_20", 8'd10, 8'd20, 1, 2);
   endtask

   task automatic test_truncation();
      run_one("trunc_22_11", 8'd22, 8'd11, 2, 1);
   endtask

   task automatic test_zero();
      int t;
      run_one("zero_pulse", 8'd0, 8'd0, 1, 1);
      t = 0;
      while (soc1 !== 1'b1 && t < 5) begin
         @(negedge clock);
         t++;
      end
      checks++;
      if (soc1 !== 1'b1 || soc2 !== 1'b1) begin
         $display("FAIL zero_restart: soc1=%b soc2=%b, required 1 1", soc1, soc2);
         failures++;
      end
   endtask

   task automatic test_max();
      run_one("max_255_255", 8'd255, 8'd255, 1, 3);
   endtask

   task automatic test_back_to_back();
      logic [7:0] a;
      logic [7:0] b;
      for (int i = 0; i < 16; i++) begin
         a = 8'(i + 10);
         b = 8'(2 * (i + 10));
         if (i % 2 == 1) run_one("b2b", b, a, $urandom_range(1, 3), $urandom_range(1, 3));
         else            run_one("b2b", a, b, $urandom_range(1, 3), $urandom_range(1, 3));
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++)
         run_one("random", 8'($urandom_range(0, 120)), 8'($urandom_range(0, 120)),
                 $urandom_range(1, 4), $urandom_range(1, 4));
   endtask

   task automatic test_reset_mid_pulse();
      bit ok;
      start_conv(8'd200, 8'd100, 1, 1, ok);
      if (ok) begin
         repeat (10) begin
            @(negedge clock);
            x1 = 8'($urandom);
            x2 = 8'($urandom);
         end
         checks++;
         if (out !== 1'b1) begin
            $display("FAIL mid_pulse_high: out=%b, required 1", out);
            failures++;
         end
         reset_ = 1'b0;
         @(negedge clock);
         checks++;
         if (out !== 1'b0 || soc1 !== 1'b0 || soc2 !== 1'b0) begin
            $display("FAIL reset_abort: out=%b soc1=%b soc2=%b, required 0 0 0", out, soc1, soc2);
            failures++;
         end
         reset_ = 1'b1;
         run_one("after_reset", 8'd40, 8'd13, 2, 1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_truncation();
      test_zero();
      test_max();
      test_back_to_back();
      test_random();
      test_reset_mid_pulse();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_abc
